divu_hilo_unit: RTL and testbench
=================================

Name: divu_hilo_unit

Overview:
- Consumer end of the function-code control bus for the divider path.
- Watches the 6-bit function code, runs a 32-step unsigned restoring divide when the code is DIVU, and commits the result into the HI/LO registers when the controller issues the HiLo-open code (6'b111111).
- Serves MFHI/MFLO reads onto the result mux.
- Sits between the ALU control block (SignaltoDIV) and the datapath output mux.

Parameters:
- WIDTH, 32, operand width; HI/LO width.
- STEPS, 32, iterations per divide; must equal WIDTH.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- Signal  input  6  function code from control (DIVU=6'b011011, MFHI=6'b010000, MFLO=6'b010010, OPEN=6'b111111)
- dataA  input  WIDTH  dividend
- dataB  input  WIDTH  divisor
- dataOut  output  WIDTH  HI on MFHI, LO on MFLO, else 0 (combinational from HI/LO)
- busy  output  1  divide in progress
- done  output  1  quotient/remainder valid, not yet committed
- div0  output  1  last started divide had divisor 0 (sticky until next start)

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, HI=0, LO=0, rem=0, quo=0, divisor=0, count=0, pend=0, busy=0, done=0, div0=0. Applies mid-divide; no commit occurs.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Signal==DIVU at posedge: divisor<=dataB, quo<=dataA, rem<=0, count<=0, div0<=(dataB==0), pend<=0, go BUSY.
  - Otherwise hold.
- BUSY, each posedge while Signal==DIVU or OPEN (one restoring step):
  - Shift {rem,quo} left 1.
  - trial = {1'b0,rem_shifted} - {1'b0,divisor}, computed in WIDTH+1 bits.
  - If trial MSB==0: rem<=trial[WIDTH-1:0], quo[0]<=1; else keep rem_shifted, quo[0]<=0.
  - count<=count+1. On the 32nd step (count==STEPS-1) go DONE.
- BUSY, Signal is any other code: abort. Go IDLE, pend<=0, HI/LO untouched.
- OPEN while BUSY: set pend=1 and continue stepping. Commit on the first DONE cycle.
- Latency: load edge + 32 step edges. done asserts after the 33rd edge counting the load edge.
- DONE:
  - Signal==OPEN at posedge, or pend==1: HI<=rem, LO<=quo, pend<=0, go IDLE.
  - Signal==DIVU with pend==0: hold in DONE, no restart. This prevents a stale DIVU level from re-triggering.
  - Any other code: go IDLE without commit. Result is discarded.
- OPEN in IDLE (no divide): ignored, HI/LO unchanged.
- Divide by zero: the algorithm runs unchanged and gives LO=all ones, HI=dividend. div0=1.
- busy = (state==BUSY); done = (state==DONE).
- dataOut reflects HI/LO in the same cycle a commit completes (post-edge values).

Decomposition:
- Shared package alu_pkg:
  - Function-code constants: AND, OR, ADD, SUB, SLT, SLL, DIVU, MFHI, MFLO.
  - HILO_OPEN = 6'b111111.
  - DIV_STEPS = 32.
  - State enum {IDLE, BUSY, DONE}.
  - The control block shares this package.
- One sub-module is natural: divu_step. It is a combinational single restoring iteration: rem, quo, divisor in; rem_next, quo_next out. It is reused by any future signed divider.

Test Plan:
- Reset, then MFHI and MFLO -> dataOut=0 both; busy=0, done=0.
- dataA=100, dataB=7, DIVU held 32 edges after load, then OPEN one edge, then MFLO/MFHI -> LO=14, HI=2; done high exactly 1 cycle; dataOut=14 then 2.
- dataA=32'hFFFFFFFF, dataB=1; OPEN asserted while BUSY (step 20) -> pend commit at DONE: LO=32'hFFFFFFFF, HI=0.
- dataA=5, dataB=0, full divide + OPEN -> div0=1, LO=32'hFFFFFFFF, HI=5.
- Prior HI=2/LO=14; new divide 9/4, Signal switched to ADD at step 10 -> state IDLE, HI=2, LO=14 unchanged; next DIVU restarts with count=0.
- rst pulsed at step 16 of 1000/3 -> all outputs 0 next cycle; later OPEN alone -> HI/LO stay 0.

Source files
------------

// File: rtl/divu_hilo_unit_pkg.sv
// Shared ALU/divider definitions: function codes, HI/LO commit code,
// divider step count and the divider FSM state encoding. The ALU control
// block imports the same package so both ends agree on the function-code bus.
package divu_hilo_unit_pkg;

  localparam int unsigned FUNC_W    = 6;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned DIV_STEPS = 32;

  typedef logic [FUNC_W-1:0] func_t;

  // Function codes carried on the control bus
  localparam func_t FN_AND    = 6'b100100;
  localparam func_t FN_OR     = 6'b100101;
  localparam func_t FN_ADD    = 6'b100000;
  localparam func_t FN_SUB    = 6'b100010;
  localparam func_t FN_SLT    = 6'b101010;
  localparam func_t FN_SLL    = 6'b000000;
  localparam func_t FN_DIVU   = 6'b011011;
  localparam func_t FN_MFHI   = 6'b010000;
  localparam func_t FN_MFLO   = 6'b010010;
  localparam func_t HILO_OPEN = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Codes that keep a running divide stepping
  function automatic logic is_step_code(input func_t code);
    return (code == FN_DIVU) || (code == HILO_OPEN);
  endfunction

endpackage

// File: rtl/divu_hilo_unit_if.sv
// Function-code control bus between the ALU control block and the divider.
//   Signal  : function code from control
//   dataA   : dividend
//   dataB   : divisor
//   dataOut : HI/LO read-back on MFHI/MFLO, else 0
//   busy    : divide in progress
//   done    : result valid, not yet committed to HI/LO
//   div0    : last started divide had a zero divisor
interface divu_hilo_unit_if #(
  parameter int unsigned WIDTH = 32
);
  import divu_hilo_unit_pkg::*;

  func_t            Signal;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [WIDTH-1:0] dataOut;
  logic             busy;
  logic             done;
  logic             div0;

  modport master (
    output Signal, dataA, dataB,
    input  dataOut, busy, done, div0
  );

  modport slave (
    input  Signal, dataA, dataB,
    output dataOut, busy, done, div0
  );

endinterface

// File: rtl/divu_hilo_unit_step.sv
// One combinational restoring-divide iteration.
//   rem, quo, divisor : current partial remainder, quotient/dividend shift
//                       register and divisor
//   rem_next, quo_next: values after one shift-and-trial-subtract step
module divu_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH-1:0] quo_sh;
  logic [WIDTH:0]   trial;

  // Shift the dividend MSB into the remainder, then try subtracting the divisor
  always_comb begin
    {rem_sh, quo_sh} = {rem, quo} << 1;
    trial            = {1'b0, rem_sh} - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo_sh[WIDTH-1:1], 1'b1};
    end else begin
      rem_next = rem_sh;
      quo_next = quo_sh;
    end
  end

endmodule

// File: rtl/divu_hilo_unit.sv
// Divider consumer of the function-code bus. Runs a STEPS-iteration
// unsigned restoring divide on DIVU and commits remainder/quotient into
// HI/LO on the HiLo-open code; serves MFHI/MFLO reads.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : divu_hilo_unit_if slave (Signal, dataA, dataB in;
//         dataOut, busy, done, div0 out)
module divu_hilo_unit
  import divu_hilo_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEPS = 32
) (
  input  logic               clk,
  input  logic               rst,
  divu_hilo_unit_if.slave    bus
);

  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pend_q, pend_d;
  logic             div0_q, div0_d;

  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  divu_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (divisor_q),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      count_q   <= '0;
      pend_q    <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
      div0_q    <= div0_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    count_d   = count_q;
    pend_d    = pend_q;
    div0_d    = div0_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.Signal == FN_DIVU) begin
          divisor_d = bus.dataB;
          quo_d     = bus.dataA;
          rem_d     = '0;
          count_d   = '0;
          div0_d    = (bus.dataB == '0);
          pend_d    = 1'b0;
          state_d   = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (is_step_code(bus.Signal)) begin
          rem_d   = rem_step;
          quo_d   = quo_step;
          count_d = count_q + CNT_W'(1);
          // OPEN arriving early is remembered and honoured once the result lands
          if (bus.Signal == HILO_OPEN) begin
            pend_d = 1'b1;
          end
          if (count_q == CNT_W'(STEPS - 1)) begin
            state_d = ST_DONE;
          end
        end else begin
          pend_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      ST_DONE: begin
        if ((bus.Signal == HILO_OPEN) || pend_q) begin
          hi_d    = rem_q;
          lo_d    = quo_q;
          pend_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (bus.Signal == FN_DIVU) begin
          // A lingering DIVU level must not restart the divide
          state_d = ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // HI/LO read-back mux
  always_comb begin
    bus.dataOut = '0;
    if (bus.Signal == FN_MFHI) begin
      bus.dataOut = hi_q;
    end else if (bus.Signal == FN_MFLO) begin
      bus.dataOut = lo_q;
    end
  end

  assign bus.busy = (state_q == ST_BUSY);
  assign bus.done = (state_q == ST_DONE);
  assign bus.div0 = div0_q;

endmodule

// File: tb/tb_divu_hilo_unit.sv
// Directed self-checking bench for divu_hilo_unit.
module tb_divu_hilo_unit;
  import divu_hilo_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  divu_hilo_unit_if #(.WIDTH(32)) bus ();

  divu_hilo_unit #(.WIDTH(32), .STEPS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_div(input logic [31:0] a, input logic [31:0] b);
    bus.Signal = FN_DIVU;
    bus.dataA  = a;
    bus.dataB  = b;
    tick();
  endtask

  task automatic run_steps(input int n, input func_t code);
    for (int i = 0; i < n; i++) begin
      bus.Signal = code;
      tick();
    end
  endtask

  task automatic open_commit();
    bus.Signal = HILO_OPEN;
    tick();
    bus.Signal = FN_SLL;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.Signal = FN_SLL;
    bus.dataA  = '0;
    bus.dataB  = '0;
    tick();
    tick();
    rst = 1'b0;
    bus.Signal = FN_MFHI; #1;
    checks++; if (bus.dataOut !== 32'h0) begin errors++; $display("FAIL reset_mfhi: got %0h want 0", bus.dataOut); end
    bus.Signal = FN_MFLO; #1;
    checks++; if (bus.dataOut !== 32'h0) begin errors++; $display("FAIL reset_mflo: got %0h want 0", bus.dataOut); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", bus.done); end
    checks++; if (bus.div0 !== 1'b0) begin errors++; $display("FAIL reset_div0: got %0b want 0", bus.div0); end
  endtask

  task automatic test_divide_basic();
    start_div(32'd100, 32'd7);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_load: got %0b want 1", bus.busy); end
    run_steps(31, FN_DIVU);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_edge32: got %0b want 0", bus.done); end
    run_steps(1, FN_DIVU);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL basic_done_edge33: got %0b want 1", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done: got %0b want 0", bus.busy); end
    open_commit();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_one_cycle: got %0b want 0", bus.done); end
    bus.Signal = FN_MFLO; #1;
    checks++; if (bus.dataOut !== 32'd14) begin errors++; $display("FAIL basic_lo: got %0d want 14", bus.dataOut); end
    bus.Signal = FN_MFHI; #1;
    checks++; if (bus.dataOut !== 32'd2) begin errors++; $display("FAIL basic_hi: got %0d want 2", bus.dataOut); end
  endtask

  task automatic test_done_hold();
    start_div(32'd20, 32'd6);
    run_steps(32, FN_DIVU);
    run_steps(2, FN_DIVU);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL hold_done: got %0b want 1", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL hold_no_restart: got %0b want 0", bus.busy); end
    bus.Signal = FN_MFLO; #1;
    checks++; if (bus.dataOut !== 32'd14) begin errors++; $display("FAIL hold_lo_uncommitted: got %0d want 14", bus.dataOut); end
    open_commit();
    bus.Signal = FN_MFLO; #1;
    checks++; if (bus.dataOut !== 32'd3) begin errors++; $display("FAIL hold_lo: got %0d want 3", bus.dataOut); end
    bus.Signal = FN_MFHI; #1;
    checks++; if (bus.dataOut !== 32'd2) begin errors++; $display("FAIL hold_hi: got %0d want 2", bus.dataOut); end
  endtask

  task automatic test_open_pending();
    start_div(32'hFFFF_FFFF, 32'd1);
    run_steps(19, FN_DIVU);
    run_steps(1, HILO_OPEN);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL pend_still_busy: got %0b want 1", bus.busy); end
    run_steps(12, FN_DIVU);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL pend_done: got %0b want 1", bus.done); end
    bus.Signal = FN_MFLO;
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL pend_committed_idle: got %0b want 0", bus.done); end
    checks++; if (bus.dataOut !== 32'hFFFF_FFFF) begin errors++; $display("FAIL pend_lo: got %0h want ffffffff", bus.dataOut); end
    bus.Signal = FN_MFHI; #1;
    checks++; if (bus.dataOut !== 32'h0) begin errors++; $display("FAIL pend_hi: got %0h want 0", bus.dataOut); end
  endtask

  task automatic test_div_zero();
    start_div(32'd5, 32'd0);
    checks++; if (bus.div0 !== 1'b1) begin errors++; $display("FAIL div0_flag_load: got %0b want 1", bus.div0); end
    run_steps(32, FN_DIVU);
    open_commit();
    checks++; if (bus.div0 !== 1'b1) begin errors++; $display("FAIL div0_sticky: got %0b want 1", bus.div0); end
    bus.Signal = FN_MFLO; #1;
    checks++; if (bus.dataOut !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo: got %0h want ffffffff", bus.dataOut); end
    bus.Signal = FN_MFHI; #1;
    checks++; if (bus.dataOut !== 32'd5) begin errors++; $display("FAIL div0_hi: got %0h want 5", bus.dataOut); end
  endtask

  task automatic test_abort();
    start_div(32'd100, 32'd7);
    checks++; if (bus.div0 !== 1'b0) begin errors++; $display("FAIL abort_div0_cleared: got %0b want 0", bus.div0); end
    run_steps(32, FN_DIVU);
    open_commit();
    start_div(32'd9, 32'd4);
    run_steps(9, FN_DIVU);
    run_steps(1, FN_ADD);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done: got %0b want 0", bus.done); end
    bus.Signal = FN_MFHI; #1;
    checks++; if (bus.dataOut !== 32'd2) begin errors++; $display("FAIL abort_hi_kept: got %0d want 2", bus.dataOut); end
    bus.Signal = FN_MFLO; #1;
    checks++; if (bus.dataOut !== 32'd14) begin errors++; $display("FAIL abort_lo_kept: got %0d want 14", bus.dataOut); end
    start_div(32'd9, 32'd4);
    run_steps(31, FN_DIVU);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL restart_done_edge32: got %0b want 0", bus.done); end
    run_steps(1, FN_DIVU);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL restart_done_edge33: got %0b want 1", bus.done); end
    open_commit();
    bus.Signal = FN_MFLO; #1;
    checks++; if (bus.dataOut !== 32'd2) begin errors++; $display("FAIL restart_lo: got %0d want 2", bus.dataOut); end
    bus.Signal = FN_MFHI; #1;
    checks++; if (bus.dataOut !== 32'd1) begin errors++; $display("FAIL restart_hi: got %0d want 1", bus.dataOut); end
  endtask

  task automatic test_reset_mid();
    start_div(32'd1000, 32'd3);
    run_steps(15, FN_DIVU);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %0b want 1", bus.busy); end
    rst = 1'b1;
    bus.Signal = FN_DIVU;
    tick();
    rst = 1'b0;
    bus.Signal = FN_MFHI; #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %0b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %0b want 0", bus.done); end
    checks++; if (bus.div0 !== 1'b0) begin errors++; $display("FAIL rstmid_div0: got %0b want 0", bus.div0); end
    checks++; if (bus.dataOut !== 32'h0) begin errors++; $display("FAIL rstmid_hi: got %0h want 0", bus.dataOut); end
    bus.Signal = FN_MFLO; #1;
    checks++; if (bus.dataOut !== 32'h0) begin errors++; $display("FAIL rstmid_lo: got %0h want 0", bus.dataOut); end
    open_commit();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL open_idle_busy: got %0b want 0", bus.busy); end
    bus.Signal = FN_MFHI; #1;
    checks++; if (bus.dataOut !== 32'h0) begin errors++; $display("FAIL open_idle_hi: got %0h want 0", bus.dataOut); end
    bus.Signal = FN_MFLO; #1;
    checks++; if (bus.dataOut !== 32'h0) begin errors++; $display("FAIL open_idle_lo: got %0h want 0", bus.dataOut); end
  endtask

  initial begin
    rst        = 1'b1;
    bus.Signal = FN_SLL;
    bus.dataA  = '0;
    bus.dataB  = '0;
    test_reset();
    test_divide_basic();
    test_done_hold();
    test_open_pending();
    test_div_zero();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
